// File: rtl/arm_alu_pkg.sv
// Shared constants for the ARM execute unit: opcodes, shift types and NZCV bit positions.
// ARM_ALU_REG_SHIFT_EN (see arm_barrel_shifter) enables register-specified shift amounts.
package arm_alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_e;

  localparam int FLAG_N = 31;
  localparam int FLAG_Z = 30;
  localparam int FLAG_C = 29;
  localparam int FLAG_V = 28;

  // Compare/test opcodes (0x8-0xB) only update flags.
  function automatic logic is_cmp_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/arm_barrel_shifter.sv
// Combinational ARM shifter producing operand 2 and the shifter carry-out.
// Register-specified shifts are honoured only when ARM_ALU_REG_SHIFT_EN is defined.
module arm_barrel_shifter
  import arm_alu_pkg::*;
(
  input  logic [DATA_W-1:0] shift_in,
  input  logic [1:0]        shift_type,
  input  logic [4:0]        shift_imm,
  input  logic [7:0]        rs_shift,
  input  logic              is_imm_32,
  input  logic              is_use_rs,
  input  logic              carry_in,
  output logic [DATA_W-1:0] op2,
  output logic              shifter_carry
);

  logic       use_rs;
  logic [7:0] rs_amt;

`ifdef ARM_ALU_REG_SHIFT_EN
  assign use_rs = is_use_rs;
  assign rs_amt = rs_shift;
`else
  logic unused_rs;
  assign unused_rs = ^{is_use_rs, rs_shift};
  assign use_rs    = 1'b0;
  assign rs_amt    = 8'd0;
`endif

  // Shift by 1..31; the 33-bit working value carries the last bit shifted out.
  function automatic logic [DATA_W:0] shift_core(input logic [DATA_W-1:0] x,
                                                  input logic [1:0] st,
                                                  input logic [4:0] amt);
    logic [DATA_W:0]   t;
    logic [DATA_W-1:0] r;
    case (st)
      SH_LSL: begin
        t = {1'b0, x} << amt;
        return t;
      end
      SH_LSR: begin
        t = {x, 1'b0} >> amt;
        return {t[0], t[DATA_W:1]};
      end
      SH_ASR: begin
        t = $unsigned($signed({x, 1'b0}) >>> amt);
        return {t[0], t[DATA_W:1]};
      end
      default: begin
        r = (x >> amt) | (x << (6'd32 - {1'b0, amt}));
        return {r[DATA_W-1], r};
      end
    endcase
  endfunction

  logic [4:0]        rot;
  logic [DATA_W:0]   sh;
  logic [DATA_W-1:0] imm_ext;

  assign rot     = {shift_imm[3:0], 1'b0};
  assign imm_ext = {24'd0, shift_in[7:0]};

  always_comb begin
    op2           = shift_in;
    shifter_carry = carry_in;
    sh            = '0;
    if (is_imm_32) begin
      if (rot != 5'd0) begin
        sh            = shift_core(imm_ext, SH_ROR, rot);
        op2           = sh[DATA_W-1:0];
        shifter_carry = sh[DATA_W];
      end else begin
        op2 = imm_ext;
      end
    end else if (use_rs) begin
      if (rs_amt != 8'd0) begin
        // Amounts of 32 and above collapse to the architectural fill values.
        case (shift_type)
          SH_LSL: begin
            if (rs_amt < 8'd32) begin
              sh = shift_core(shift_in, SH_LSL, rs_amt[4:0]);
              {shifter_carry, op2} = sh;
            end else begin
              op2           = '0;
              shifter_carry = (rs_amt == 8'd32) ? shift_in[0] : 1'b0;
            end
          end
          SH_LSR: begin
            if (rs_amt < 8'd32) begin
              sh = shift_core(shift_in, SH_LSR, rs_amt[4:0]);
              {shifter_carry, op2} = sh;
            end else begin
              op2           = '0;
              shifter_carry = (rs_amt == 8'd32) ? shift_in[DATA_W-1] : 1'b0;
            end
          end
          SH_ASR: begin
            if (rs_amt < 8'd32) begin
              sh = shift_core(shift_in, SH_ASR, rs_amt[4:0]);
              {shifter_carry, op2} = sh;
            end else begin
              op2           = {DATA_W{shift_in[DATA_W-1]}};
              shifter_carry = shift_in[DATA_W-1];
            end
          end
          default: begin
            if (rs_amt[4:0] == 5'd0) begin
              shifter_carry = shift_in[DATA_W-1];
            end else begin
              sh = shift_core(shift_in, SH_ROR, rs_amt[4:0]);
              {shifter_carry, op2} = sh;
            end
          end
        endcase
      end
    end else begin
      if (shift_imm != 5'd0) begin
        sh = shift_core(shift_in, shift_type, shift_imm);
        {shifter_carry, op2} = sh;
      end else begin
        case (shift_type)
          SH_LSL: ;
          SH_LSR: begin
            op2           = '0;
            shifter_carry = shift_in[DATA_W-1];
          end
          SH_ASR: begin
            op2           = {DATA_W{shift_in[DATA_W-1]}};
            shifter_carry = shift_in[DATA_W-1];
          end
          default: begin
            op2           = {carry_in, shift_in[DATA_W-1:1]};
            shifter_carry = shift_in[0];
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/arm_alu.sv
// Registered ARM data-processing execute unit: barrel shifter feeding a 16-opcode ALU,
// one register stage. Register-specified shifts controlled by ARM_ALU_REG_SHIFT_EN.
module arm_alu
  import arm_alu_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              enable,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] shift_in,
  input  logic [1:0]        shift_type,
  input  logic [4:0]        shift_imm,
  input  logic [7:0]        rs_shift,
  input  logic              is_imm_32,
  input  logic              is_use_rs,
  input  logic              carry_in,
  input  logic              overflow_in,
  output logic [DATA_W-1:0] result,
  output logic              negative_flag,
  output logic              zero_flag,
  output logic              carry_out_flag,
  output logic              overflow_flag,
  output logic              write_rd,
  output logic              valid
);

  logic [DATA_W-1:0] op2;
  logic              sh_carry;

  arm_barrel_shifter u_shifter (
    .shift_in      (shift_in),
    .shift_type    (shift_type),
    .shift_imm     (shift_imm),
    .rs_shift      (rs_shift),
    .is_imm_32     (is_imm_32),
    .is_use_rs     (is_use_rs),
    .carry_in      (carry_in),
    .op2           (op2),
    .shifter_carry (sh_carry)
  );

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] s);
    return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
  endfunction

  logic signed [DATA_W-1:0] add_x, add_y, alu_res;
  logic                     add_ci, arith, alu_c, alu_v;
  logic [DATA_W:0]          sum;

  // Every arithmetic op is x + y + ci; subtraction inverts the subtrahend.
  always_comb begin
    alu_res = '0;
    arith   = 1'b0;
    add_x   = operand1;
    add_y   = op2;
    add_ci  = 1'b0;
    case (opcode)
      OP_AND, OP_TST: alu_res = operand1 & op2;
      OP_EOR, OP_TEQ: alu_res = operand1 ^ op2;
      OP_ORR:         alu_res = operand1 | op2;
      OP_MOV:         alu_res = op2;
      OP_BIC:         alu_res = operand1 & ~op2;
      OP_MVN:         alu_res = ~op2;
      OP_SUB, OP_CMP: begin arith = 1'b1; add_y = ~op2; add_ci = 1'b1; end
      OP_RSB:         begin arith = 1'b1; add_x = op2; add_y = ~operand1; add_ci = 1'b1; end
      OP_ADD, OP_CMN: arith = 1'b1;
      OP_ADC:         begin arith = 1'b1; add_ci = carry_in; end
      OP_SBC:         begin arith = 1'b1; add_y = ~op2; add_ci = carry_in; end
      OP_RSC:         begin arith = 1'b1; add_x = op2; add_y = ~operand1; add_ci = carry_in; end
      default:        ;
    endcase
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_ci};
    alu_c = sh_carry;
    alu_v = overflow_in;
    if (arith) begin
      alu_res = sum[DATA_W-1:0];
      alu_c   = sum[DATA_W];
      alu_v   = add_ovf(add_x, add_y, sum[DATA_W-1:0]);
    end
  end

  // ---- stage p1: execute result register ----
  logic [DATA_W-1:0]      res_p1_d,   res_p1_q;
  logic [FLAG_N:FLAG_V]   nzcv_p1_d,  nzcv_p1_q;
  logic                   wrd_p1_d,   wrd_p1_q;
  logic                   vld_p1_d,   vld_p1_q;

  always_comb begin
    res_p1_d  = res_p1_q;
    nzcv_p1_d = nzcv_p1_q;
    wrd_p1_d  = wrd_p1_q;
    vld_p1_d  = enable;
    if (enable) begin
      res_p1_d          = alu_res;
      nzcv_p1_d[FLAG_N] = alu_res[DATA_W-1];
      nzcv_p1_d[FLAG_Z] = (alu_res == '0);
      nzcv_p1_d[FLAG_C] = alu_c;
      nzcv_p1_d[FLAG_V] = alu_v;
      wrd_p1_d          = !is_cmp_op(opcode);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      res_p1_q  <= '0;
      nzcv_p1_q <= '0;
      wrd_p1_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
    end else begin
      res_p1_q  <= res_p1_d;
      nzcv_p1_q <= nzcv_p1_d;
      wrd_p1_q  <= wrd_p1_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  assign result         = res_p1_q;
  assign negative_flag  = nzcv_p1_q[FLAG_N];
  assign zero_flag      = nzcv_p1_q[FLAG_Z];
  assign carry_out_flag = nzcv_p1_q[FLAG_C];
  assign overflow_flag  = nzcv_p1_q[FLAG_V];
  assign write_rd       = wrd_p1_q;
  assign valid          = vld_p1_q;

endmodule

// File: tb/tb_arm_alu.sv
// Testbench for arm_alu: directed vector table, hold/reset sequences and a randomized
// run against an arithmetic reference model. Follows ARM_ALU_REG_SHIFT_EN like the RTL.
module tb_arm_alu;
  import arm_alu_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset, enable, is_imm_32, is_use_rs, carry_in, overflow_in;
  logic [3:0]  opcode;
  logic [31:0] operand1, shift_in, result;
  logic [1:0]  shift_type;
  logic [4:0]  shift_imm;
  logic [7:0]  rs_shift;
  logic        negative_flag, zero_flag, carry_out_flag, overflow_flag, write_rd, valid;

  arm_alu dut (
    .clk(clk), .n_reset(n_reset), .enable(enable), .opcode(opcode),
    .operand1(operand1), .shift_in(shift_in), .shift_type(shift_type),
    .shift_imm(shift_imm), .rs_shift(rs_shift), .is_imm_32(is_imm_32),
    .is_use_rs(is_use_rs), .carry_in(carry_in), .overflow_in(overflow_in),
    .result(result), .negative_flag(negative_flag), .zero_flag(zero_flag),
    .carry_out_flag(carry_out_flag), .overflow_flag(overflow_flag),
    .write_rd(write_rd), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, si;
    logic [1:0]  st;
    logic [4:0]  simm;
    logic [7:0]  rs;
    logic        imm32, use_rs, cin, vin;
  } in_t;

  typedef struct {
    in_t         i;
    logic [31:0] res;
    logic [3:0]  nzcv;
    logic        wr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] si,
                             input logic [1:0] st, input logic [4:0] simm, input logic [7:0] rs,
                             input logic imm32, input logic use_rs, input logic cin,
                             input logic vin);
    in_t t;
    t.op = op; t.a = a; t.si = si; t.st = st; t.simm = simm; t.rs = rs;
    t.imm32 = imm32; t.use_rs = use_rs; t.cin = cin; t.vin = vin;
    return t;
  endfunction

  task automatic drive(input in_t t, input logic en);
    opcode = t.op; operand1 = t.a; shift_in = t.si; shift_type = t.st;
    shift_imm = t.simm; rs_shift = t.rs; is_imm_32 = t.imm32; is_use_rs = t.use_rs;
    carry_in = t.cin; overflow_in = t.vin; enable = en;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference shifter: {carry, op2} from the architectural rules using wide arithmetic.
  function automatic logic [32:0] m_shift(input in_t t);
    logic [31:0] x, r;
    logic        c, use_rs;
    longint      w;
    int          n;
    x = t.si;
`ifdef ARM_ALU_REG_SHIFT_EN
    use_rs = t.use_rs;
`else
    use_rs = 1'b0;
`endif
    if (t.imm32) begin
      n = 2 * int'(t.simm[3:0]);
      r = {24'd0, x[7:0]};
      for (int k = 0; k < n; k++) r = {r[0], r[31:1]};
      c = (n == 0) ? t.cin : r[31];
      return {c, r};
    end
    n = use_rs ? int'(t.rs) : int'(t.simm);
    if (n == 0) begin
      if (use_rs || t.st == 2'd0) return {t.cin, x};
      if (t.st == 2'd3) return {x[0], t.cin, x[31:1]};
      n = 32;
    end
    case (t.st)
      2'd0: begin
        if (n > 32) return 33'd0;
        w = longint'({32'd0, x}) << n;
        return {w[32], w[31:0]};
      end
      2'd1: begin
        if (n > 32) return 33'd0;
        w = longint'({x, 32'd0});
        w = longint'(64'({x, 32'd0}) >> n);
        return {w[31], w[63:32]};
      end
      2'd2: begin
        if (n >= 32) return {x[31], {32{x[31]}}};
        w = longint'({x, 32'd0});
        w = w >>> n;
        return {w[31], w[63:32]};
      end
      default: begin
        r = x;
        for (int k = 0; k < n % 32; k++) r = {r[0], r[31:1]};
        return {r[31], r};
      end
    endcase
  endfunction

  // Reference ALU: unsigned/signed 64-bit arithmetic gives C and V directly.
  task automatic model(input in_t t, output logic [31:0] res, output logic [3:0] nzcv,
                       output logic wr);
    logic [32:0] sh;
    logic [31:0] b;
    longint      ua, ub, sa, sb, u, s;
    logic        c, v, sub_kind;
    sh = m_shift(t);
    b  = sh[31:0];
    c  = sh[32];
    v  = t.vin;
    ua = longint'({32'd0, t.a}); ub = longint'({32'd0, b});
    sa = longint'($signed(t.a)); sb = longint'($signed(b));
    u = 0; s = 0; sub_kind = 1'b0;
    res = 32'd0;
    case (t.op)
      OP_AND, OP_TST: res = t.a & b;
      OP_EOR, OP_TEQ: res = t.a ^ b;
      OP_ORR:         res = t.a | b;
      OP_MOV:         res = b;
      OP_BIC:         res = t.a & ~b;
      OP_MVN:         res = ~b;
      OP_ADD, OP_CMN: begin u = ua + ub; s = sa + sb; end
      OP_ADC:         begin u = ua + ub + t.cin; s = sa + sb + t.cin; end
      OP_SUB, OP_CMP: begin u = ua - ub; s = sa - sb; sub_kind = 1'b1; end
      OP_SBC:         begin u = ua - ub - (1 - t.cin); s = sa - sb - (1 - t.cin); sub_kind = 1'b1; end
      OP_RSB:         begin u = ub - ua; s = sb - sa; sub_kind = 1'b1; end
      default:        begin u = ub - ua - (1 - t.cin); s = sb - sa - (1 - t.cin); sub_kind = 1'b1; end
    endcase
    if (t.op inside {OP_ADD, OP_CMN, OP_ADC, OP_SUB, OP_CMP, OP_SBC, OP_RSB, OP_RSC}) begin
      res = u[31:0];
      c   = sub_kind ? (u >= 0) : (u > longint'(32'hFFFF_FFFF));
      v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    nzcv = {res[31], res == 32'd0, c, v};
    wr   = !(t.op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
  endtask

  function automatic in_t rnd_in();
    in_t t;
    t = mk(4'($urandom), $urandom, $urandom, 2'($urandom), 5'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    case ($urandom_range(0, 3))
      0: t.rs = 8'($urandom_range(0, 33));
      1: t.rs = 8'd32;
      2: t.rs = {3'($urandom), 5'd0};
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) t.si = 32'h8000_0000;
    if ($urandom_range(0, 7) == 0) t.a  = t.si;
    return t;
  endfunction

  vec_t        vecs[12];
  logic [31:0] e_res;
  logic [3:0]  e_nzcv;
  logic        e_wr, en;
  in_t         t;

  initial begin
    n_reset = 1'b0;
    drive(mk(4'd0, 32'd0, 32'd0, 2'd0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);

    vecs[0]  = '{mk(OP_ADD, 32'hFFFF_FFFF, 32'd1, 2'd0, 5'd0, 8'd0, 0, 0, 0, 0), 32'h0, 4'b0110, 1'b1};
    vecs[1]  = '{mk(OP_SUB, 32'd5, 32'd7, 2'd0, 5'd0, 8'd0, 0, 0, 0, 0), 32'hFFFF_FFFE, 4'b1000, 1'b1};
    vecs[2]  = '{mk(OP_ADD, 32'h7FFF_FFFF, 32'd1, 2'd0, 5'd0, 8'd0, 0, 0, 0, 0), 32'h8000_0000, 4'b1001, 1'b1};
    vecs[3]  = '{mk(OP_MOV, 32'd0, 32'hFF, 2'd0, 5'd4, 8'd0, 1, 0, 0, 0), 32'hFF00_0000, 4'b1010, 1'b1};
    vecs[4]  = '{mk(OP_MOV, 32'd0, 32'hFF, 2'd0, 5'd0, 8'd0, 1, 0, 0, 0), 32'h0000_00FF, 4'b0000, 1'b1};
    vecs[5]  = '{mk(OP_MOV, 32'd0, 32'h3, 2'd3, 5'd0, 8'd0, 0, 0, 1, 0), 32'h8000_0001, 4'b1010, 1'b1};
`ifdef ARM_ALU_REG_SHIFT_EN
    vecs[6]  = '{mk(OP_MOV, 32'd0, 32'hFFFF_FFFF, 2'd1, 5'd0, 8'd40, 0, 1, 0, 0), 32'h0, 4'b0100, 1'b1};
`else
    vecs[6]  = '{mk(OP_MOV, 32'd0, 32'hFFFF_FFFF, 2'd1, 5'd0, 8'd40, 0, 1, 0, 0), 32'h0, 4'b0110, 1'b1};
`endif
    vecs[7]  = '{mk(OP_MOV, 32'd0, 32'h8000_0000, 2'd2, 5'd0, 8'd0, 0, 0, 0, 0), 32'hFFFF_FFFF, 4'b1010, 1'b1};
    vecs[8]  = '{mk(OP_RSB, 32'd1, 32'd0, 2'd0, 5'd0, 8'd0, 0, 0, 0, 0), 32'hFFFF_FFFF, 4'b1000, 1'b1};
    vecs[9]  = '{mk(OP_ADC, 32'hFFFF_FFFF, 32'd0, 2'd0, 5'd0, 8'd0, 0, 0, 1, 0), 32'h0, 4'b0110, 1'b1};
    vecs[10] = '{mk(OP_BIC, 32'hFF, 32'hF0, 2'd0, 5'd0, 8'd0, 0, 0, 0, 1), 32'h0F, 4'b0001, 1'b1};
    vecs[11] = '{mk(OP_CMP, 32'd3, 32'd3, 2'd0, 5'd0, 8'd0, 0, 0, 0, 0), 32'h0, 4'b0110, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_nzcv", {28'd0, negative_flag, zero_flag, carry_out_flag, overflow_flag}, 32'd0);
    chk("reset_wr", {31'd0, write_rd}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    n_reset = 1'b1;
    step();

    foreach (vecs[k]) begin
      drive(vecs[k].i, 1'b1);
      step();
      enable = 1'b0;
      chk($sformatf("vec%0d_valid", k), {31'd0, valid}, 32'd1);
      chk($sformatf("vec%0d_result", k), result, vecs[k].res);
      chk($sformatf("vec%0d_nzcv", k),
          {28'd0, negative_flag, zero_flag, carry_out_flag, overflow_flag}, {28'd0, vecs[k].nzcv});
      chk($sformatf("vec%0d_wr", k), {31'd0, write_rd}, {31'd0, vecs[k].wr});
    end

    // Hold after CMP with enable low and the inputs changing underneath.
    for (int k = 0; k < 3; k++) begin
      drive(mk(OP_MVN, 32'h1234, 32'h5678, 2'd1, 5'd3, 8'd0, 0, 0, 1, 1), 1'b0);
      step();
      chk("hold_valid", {31'd0, valid}, 32'd0);
      chk("hold_state", {result[27:0], negative_flag, zero_flag, carry_out_flag, overflow_flag},
          {28'd0, 4'b0110});
      chk("hold_wr", {31'd0, write_rd}, 32'd0);
    end

    e_res = result; e_nzcv = 4'b0110; e_wr = 1'b0;
    for (int k = 0; k < 400; k++) begin
      t  = rnd_in();
      en = ($urandom_range(0, 3) != 0);
      drive(t, en);
      step();
      if (en) model(t, e_res, e_nzcv, e_wr);
      chk("rand_valid", {31'd0, valid}, {31'd0, en});
      chk("rand_result", result, e_res);
      chk("rand_nzcv", {28'd0, negative_flag, zero_flag, carry_out_flag, overflow_flag},
          {28'd0, e_nzcv});
      chk("rand_wr", {31'd0, write_rd}, {31'd0, e_wr});
    end

    // Asynchronous reset while valid is high.
    drive(mk(OP_MVN, 32'd0, 32'h0, 2'd0, 5'd0, 8'd0, 0, 0, 0, 1), 1'b1);
    @(posedge clk);
    #1;
    chk("prereset_valid", {31'd0, valid}, 32'd1);
    enable = 1'b0;
    #1 n_reset = 1'b0;
    #1;
    chk("areset_result", result, 32'd0);
    chk("areset_nzcv", {28'd0, negative_flag, zero_flag, carry_out_flag, overflow_flag}, 32'd0);
    chk("areset_wr_valid", {30'd0, write_rd, valid}, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    chk("postreset_valid_result", {valid, result[30:0]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
